div_sequencer: RTL and testbench

- Issue/retire wrapper directly upstream of the radix-4 SRT divider in the ALU.
- Accepts RISC-V M-extension DIV/DIVU/REM/REMU micro-ops from the ALU dispatch over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally, without engaging the divider. All other ops launch the divider, wait for its done pulse, select quotient or remainder, and present a tagged result to writeback over valid/ready.

---
 rtl/div_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_div_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Issue/retire sequencer for the radix-4 SRT divider: handles divide-by-zero and
// signed overflow locally. Optional result cache: `define DIV_SEQ_RESULT_CACHE_EN.
package core_config_pkg;
  parameter int unsigned XLEN = 32;
endpackage

module div_sequencer #(
  parameter int unsigned XLEN           = core_config_pkg::XLEN,
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [XLEN-1:0]  op_rs1,
  input  logic [XLEN-1:0]  op_rs2,
  input  logic [TAG_W-1:0] op_tag,
  input  logic             flush,
  output logic             div_start,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  output logic             div_is_signed,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  input  logic             div_done,
  input  logic             div_by_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             timeout_err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RESP} state_e;

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q, state_d;
  logic [XLEN-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sgn_q, sgn_d, rem_q, rem_d;
  logic               to_q, to_d, dseen_q, dseen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic               accept, op_signed, ovf, wd_exp, c_hit, c_fill;
  logic [XLEN-1:0]    c_res;
  logic               unused_ok;

  assign unused_ok = div_by_zero;

  assign accept    = (state_q == IDLE) && op_valid && !flush;
  assign op_signed = ~op_code[0];
  assign ovf       = op_signed && (op_rs1 == INT_MIN) && (op_rs2 == '1);
  assign cnt_nxt   = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CNT_W'(1);
  assign wd_exp    = (cnt_nxt == CNT_LIM);
  assign c_fill    = (state_q == WAIT) && !flush && div_done;

`ifdef DIV_SEQ_RESULT_CACHE_EN
  logic            c_vld_q, c_sgn_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q;

  assign c_hit = c_vld_q && (op_rs1 == c_a_q) && (op_rs2 == c_b_q) && (op_signed == c_sgn_q);
  assign c_res = op_code[1] ? c_rem_q : c_quo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else if (c_fill) begin
      c_vld_q <= 1'b1;
      c_sgn_q <= sgn_q;
      c_a_q   <= a_q;
      c_b_q   <= b_q;
      c_quo_q <= div_quotient;
      c_rem_q <= div_remainder;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = c_fill;
  assign c_hit       = 1'b0;
  assign c_res       = '0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    tag_d   = tag_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    to_d    = to_q;
    dseen_d = dseen_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = op_rs1;
          b_d   = op_rs2;
          tag_d = op_tag;
          sgn_d = op_signed;
          rem_d = op_code[1];
          if (op_rs2 == '0) begin
            res_d   = op_code[1] ? op_rs1 : '1;
            state_d = RESP;
          end else if (ovf) begin
            res_d   = op_code[1] ? '0 : op_rs1;
            state_d = RESP;
          end else if (c_hit) begin
            res_d   = c_res;
            state_d = RESP;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        dseen_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_nxt;
        if (flush) begin
          // A done coincident with the flush is remembered so DRAIN exits at once.
          dseen_d = div_done;
          state_d = DRAIN;
        end else if (div_done) begin
          res_d   = rem_q ? div_remainder : div_quotient;
          state_d = RESP;
        end else if (wd_exp) begin
          to_d    = 1'b1;
          res_d   = '1;
          state_d = RESP;
        end
      end
      DRAIN: begin
        cnt_d = cnt_nxt;
        if (div_done || dseen_q) begin
          state_d = IDLE;
        end else if (wd_exp) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush || res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= 1'b0;
      to_q    <= 1'b0;
      dseen_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
      dseen_q <= dseen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_ready      = (state_q == IDLE);
  assign div_start     = (state_q == LAUNCH);
  assign res_valid     = (state_q == RESP);
  assign div_dividend  = a_q;
  assign div_divisor   = b_q;
  assign div_is_signed = sgn_q;
  assign res_data      = res_q;
  assign res_tag       = tag_q;
  assign timeout_err   = to_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural divider responder.
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_ready, flush;
  logic [1:0]  op_code;
  logic [31:0] op_rs1, op_rs2;
  logic [4:0]  op_tag;
  logic        div_start, div_is_signed, div_done, div_by_zero;
  logic [31:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic        res_valid, res_ready, timeout_err;
  logic [31:0] res_data;
  logic [4:0]  res_tag;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   dones  = 0;
  int   lat    = 3;
  int   m_cnt  = 0;
  bit   m_busy = 1'b0;

  div_sequencer #(.XLEN(32), .TAG_W(5), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_tag(op_tag), .flush(flush),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_is_signed(div_is_signed), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_done(div_done), .div_by_zero(div_by_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider responder: done arrives 'lat' negedges after the start pulse.
  always @(negedge clk) begin
    div_done = 1'b0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt <= 0) begin
        m_busy   = 1'b0;
        div_done = 1'b1;
        dones++;
        if (div_is_signed) begin
          div_quotient  = $signed(div_dividend) / $signed(div_divisor);
          div_remainder = $signed(div_dividend) % $signed(div_divisor);
        end else begin
          div_quotient  = div_dividend / div_divisor;
          div_remainder = div_dividend % div_divisor;
        end
      end
    end
    if (div_start) begin
      starts++;
      m_busy = 1'b1;
      m_cnt  = lat;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready && !flush) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none", res_data);
      end else begin
        e = sbq.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_tag", {27'b0, res_tag}, {27'b0, e.tag});
      end
    end
  end

  task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input bit push, input logic [31:0] expv);
    int n;
    if (push) sbq.push_back(exp_t'{data: expv, tag: t});
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = code; op_rs1 = a; op_rs2 = b; op_tag = t;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (op_ready && !flush) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (sbq.size() == 0 && op_ready && !res_valid) break;
      n++;
    end
    chk("drain_scoreboard", (n < 300) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int s0, d0, n;
    bit saw_valid;
    rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_rs1 = '0; op_rs2 = '0; op_tag = '0;
    flush = 1'b0; res_ready = 1'b1; div_done = 1'b0; div_by_zero = 1'b0;
    div_quotient = '0; div_remainder = '0;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_tag", {27'b0, res_tag}, 0);
    chk("rst_dividend", div_dividend, 0);
    chk("rst_divisor", div_divisor, 0);
    chk("rst_is_signed", div_is_signed, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;

    s0 = starts;
    issue(OP_DIV, 32'd7, 32'd2, 5'd3, 1, 32'd3);
    chk("launch_start", div_start, 1);
    chk("launch_dividend", div_dividend, 32'd7);
    chk("launch_divisor", div_divisor, 32'd2);
    chk("launch_signed", div_is_signed, 1);
    wait_idle();
    chk("div_start_count", starts - s0, 1);
    issue(OP_REM, 32'd7, 32'd2, 5'd4, 1, 32'd1);
    wait_idle();

    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 1, 32'hFFFF_FFFF);
    wait_idle();
    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 32'h7FFF_FFFC);
    chk("divu_unsigned", div_is_signed, 0);
    wait_idle();

    s0 = starts;
    issue(OP_DIVU, 32'd5, 32'd0, 5'd7, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("fast_latency", res_valid, 1);
    wait_idle();
    issue(OP_REMU, 32'h1234, 32'd0, 5'd8, 1, 32'h1234);
    wait_idle();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 32'h8000_0000);
    wait_idle();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'd0);
    wait_idle();
    chk("fast_no_start", starts - s0, 0);

    lat = 10;
    d0 = dones;
    issue(OP_DIV, 32'd20, 32'd3, 5'd12, 0, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    saw_valid = 1'b0;
    n = 0;
    @(negedge clk);
    chk("drain_not_ready", op_ready, 0);
    while (!op_ready && n < 100) begin
      if (res_valid) saw_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("drain_exit", op_ready, 1);
    chk("drain_no_result", saw_valid, 0);
    chk("drain_after_done", (dones > d0) ? 32'd1 : 32'd0, 32'd1);
    lat = 3;
    issue(OP_DIV, 32'd9, 32'd3, 5'd13, 1, 32'd3);
    wait_idle();

    res_ready = 1'b0;
    issue(OP_DIVU, 32'd1, 32'd0, 5'd14, 0, 32'd0);
    @(negedge clk);
    chk("resp_flush_pre", res_valid, 1);
    @(posedge clk); #1;
    flush = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("resp_flush_drop", res_valid, 0);
    chk("resp_flush_idle", op_ready, 1);

    res_ready = 1'b0;
    issue(OP_DIVU, 32'd50, 32'd5, 5'd9, 1, 32'd10);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, 32'd10);
      chk("hold_tag", {27'b0, res_tag}, 32'd9);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle();

    s0 = starts;
    issue(OP_DIV, 32'd100, 32'd7, 5'd15, 1, 32'd14);
    wait_idle();
    issue(OP_REM, 32'd100, 32'd7, 5'd16, 1, 32'd2);
    wait_idle();
`ifdef DIV_SEQ_RESULT_CACHE_EN
    chk("cache_single_start", starts - s0, 1);
`else
    chk("nocache_two_starts", starts - s0, 2);
`endif

    chk("timeout_clear", timeout_err, 0);
    lat = 100;
    issue(OP_DIVU, 32'd10, 32'd2, 5'd17, 1, 32'hFFFF_FFFF);
    wait_idle();
    chk("timeout_set", timeout_err, 1);
    repeat (80) @(negedge clk);
    chk("late_done_ignored", res_valid, 0);
    chk("late_done_ready", op_ready, 1);
    chk("timeout_sticky", timeout_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
